hue_pwm_rainbow: RTL

HUE_PWM_RAINBOW -- requirements
Module: hue_pwm_rainbow

---
 rtl/rainbow_pkg.sv | 25 ++
 rtl/rainbow_pwm_channel.sv | 95 +++++++++
 rtl/hue_pwm_rainbow.sv | 108 ++++++++++
 3 files changed

// File: rtl/rainbow_pkg.sv
// Shared constants for the hue_pwm_rainbow slice: mode encodings, colour bit
// offsets within an LED's 3-bit group, and the six hue-wheel segment indices.
package rainbow_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_PAUSE = 2'b01,
        MODE_FIXED = 2'b10,
        MODE_OFF   = 2'b11
    } mode_e;

    localparam int unsigned R_BIT = 2;
    localparam int unsigned B_BIT = 1;
    localparam int unsigned G_BIT = 0;

    typedef enum logic [2:0] {
        SEG_0 = 3'd0,
        SEG_1 = 3'd1,
        SEG_2 = 3'd2,
        SEG_3 = 3'd3,
        SEG_4 = 3'd4,
        SEG_5 = 3'd5
    } seg_e;

endpackage

// File: rtl/rainbow_pwm_channel.sv
// One RGB LED: hue-to-RGB mapping, brightness scaling, frame-latched duty and
// active-low PWM compare. Optional gamma stage enabled by RAINBOW_GAMMA_EN.
module rainbow_pwm_channel
    import rainbow_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PWM_BITS+2:0]   hue,
    input  logic [PWM_BITS-1:0]   brightness,
    input  logic                  blank,
    input  logic [PWM_BITS-1:0]   pwm_cnt,
    input  logic                  frame_end,
    output logic [2:0]            led_n
);

    localparam int unsigned PW = PWM_BITS;
    localparam logic [PW-1:0] FS = '1;

    logic [2:0]          seg;
    logic [PW-1:0]       frac;
    logic [2:0][PW-1:0]  level;
    logic [2:0][PW-1:0]  scaled;
    logic [2:0][PW-1:0]  duty_src;
    logic [2:0][PW-1:0]  duty_d, duty_q;
    logic [2:0]          led_n_d, led_n_q;

    always_comb begin
        logic [2*PW-1:0] prod;
        prod  = '0;
        seg   = hue[PW+2:PW];
        frac  = hue[PW-1:0];
        level = '0;
        case (seg)
            SEG_0: begin level[R_BIT] = FS;        level[G_BIT] = frac;      end
            SEG_1: begin level[R_BIT] = FS - frac; level[G_BIT] = FS;        end
            SEG_2: begin level[G_BIT] = FS;        level[B_BIT] = frac;      end
            SEG_3: begin level[G_BIT] = FS - frac; level[B_BIT] = FS;        end
            SEG_4: begin level[R_BIT] = frac;      level[B_BIT] = FS;        end
            SEG_5: begin level[R_BIT] = FS;        level[B_BIT] = FS - frac; end
            default: ;
        endcase
        for (int unsigned c = 0; c < 3; c++) begin
            prod      = {{PW{1'b0}}, level[c]} * {{PW{1'b0}}, brightness};
            scaled[c] = prod[2*PW-1:PW];
        end
    end

`ifdef RAINBOW_GAMMA_EN
    logic [2:0][PW-1:0] gamma_d, gamma_q;

    always_comb begin
        logic [2*PW-1:0] sq;
        sq      = '0;
        gamma_d = '0;
        for (int unsigned c = 0; c < 3; c++) begin
            sq         = {{PW{1'b0}}, scaled[c]} * {{PW{1'b0}}, scaled[c]};
            gamma_d[c] = sq[2*PW-1:PW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) gamma_q <= '0;
        else     gamma_q <= gamma_d;
    end

    always_comb duty_src = gamma_q;
`else
    always_comb duty_src = scaled;
`endif

    // Duty only changes on the last count of a frame so a frame never mixes two duties.
    always_comb begin
        duty_d  = frame_end ? duty_src : duty_q;
        led_n_d = '1;
        for (int unsigned c = 0; c < 3; c++) begin
            led_n_d[c] = !(pwm_cnt < duty_q[c]);
        end
        if (blank) led_n_d = '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q  <= '0;
            led_n_q <= '1;
        end else begin
            duty_q  <= duty_d;
            led_n_q <= led_n_d;
        end
    end

    assign led_n = led_n_q;

endmodule

// File: rtl/hue_pwm_rainbow.sv
// Rainbow hue sweeper: step timer, base hue register, shared PWM frame counter
// and per-LED channels. Optional gamma stage enabled by RAINBOW_GAMMA_EN.
module hue_pwm_rainbow
    import rainbow_pkg::*;
#(
    parameter  int unsigned CLK_HZ     = 24_000_000,
    parameter  int unsigned CYCLE_MS   = 10_000,
    parameter  int unsigned PWM_BITS   = 8,
    parameter  int unsigned N_LEDS     = 1,
    parameter  int unsigned PHASE_STEP = 256,
    localparam int unsigned HUE_MAX    = 6 * (2 ** PWM_BITS),
    localparam int unsigned HW         = $clog2(HUE_MAX)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  hue_load,
    input  logic [HW-1:0]         hue_in,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [3*N_LEDS-1:0]   led,
    output logic [HW-1:0]         hue_out,
    output logic                  wrap
);

    // Multiply before dividing in 64 bits so slow clocks do not truncate to zero.
    localparam logic [63:0] STEP_RAW =
        64'(CLK_HZ) * 64'(CYCLE_MS) / 64'd1000 / 64'(HUE_MAX);
    localparam int unsigned STEP_TICKS = (STEP_RAW > 64'd1) ? 32'(STEP_RAW) : 1;
    localparam int unsigned SW         = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_TICKS - 1);
    localparam logic [HW-1:0] HUE_LAST  = HW'(HUE_MAX - 1);

    logic [SW-1:0]       step_cnt_d, step_cnt_q;
    logic                step_tick;
    logic [HW-1:0]       hue_d, hue_q;
    logic                wrap_d, wrap_q;
    logic [PWM_BITS-1:0] pwm_cnt_d, pwm_cnt_q;
    logic                frame_end;
    logic                blank;

    always_comb begin
        step_tick  = (step_cnt_q == STEP_LAST);
        step_cnt_d = step_tick ? '0 : step_cnt_q + SW'(1);
        pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
        frame_end  = (pwm_cnt_q == '1);
        blank      = (mode == MODE_OFF);
        hue_d      = hue_q;
        wrap_d     = 1'b0;
        if (hue_load && (hue_in <= HUE_LAST)) begin
            hue_d = hue_in;
        end else if ((mode == MODE_RUN) && step_tick) begin
            if (hue_q == HUE_LAST) begin
                hue_d  = '0;
                wrap_d = 1'b1;
            end else begin
                hue_d = hue_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_q <= '0;
            hue_q      <= '0;
            wrap_q     <= 1'b0;
            pwm_cnt_q  <= '0;
        end else begin
            step_cnt_q <= step_cnt_d;
            hue_q      <= hue_d;
            wrap_q     <= wrap_d;
            pwm_cnt_q  <= pwm_cnt_d;
        end
    end

    assign hue_out = hue_q;
    assign wrap    = wrap_q;

    for (genvar i = 0; i < N_LEDS; i++) begin : g_led
        // Offset is reduced at elaboration, so one conditional subtract keeps the sum in range.
        localparam int unsigned OFFS = (i * PHASE_STEP) % HUE_MAX;

        logic [HW:0]   hue_sum;
        logic [HW-1:0] led_hue;

        always_comb begin
            hue_sum = {1'b0, hue_q} + (HW+1)'(OFFS);
            if (hue_sum >= (HW+1)'(HUE_MAX)) begin
                led_hue = HW'(hue_sum - (HW+1)'(HUE_MAX));
            end else begin
                led_hue = hue_sum[HW-1:0];
            end
        end

        rainbow_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_channel (
            .clk        (clk),
            .rst        (rst),
            .hue        (led_hue),
            .brightness (brightness),
            .blank      (blank),
            .pwm_cnt    (pwm_cnt_q),
            .frame_end  (frame_end),
            .led_n      (led[3*i +: 3])
        );
    end

endmodule
